// File: rtl/mux_sel_pipe.sv
// N-channel operand selector feeding a two-entry elastic stage (output + skid register).
// Define MUX_SEL_PIPE_CHECK_EN to enable the sticky out-of-range selector flag sel_err.
module mux_sel_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_CH  = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      seletor,
    input  logic [N_CH*WIDTH-1:0] data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      mux_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] sel_word;
    logic             acc, pop;

    assign in_ready  = (occ_q != StTwo);
    assign out_valid = (occ_q != StEmpty);
    assign mux_out   = head_q;
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Indices with no matching channel fall through to the zero default.
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (seletor == SEL_W'(k)) begin
                sel_word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        case (occ_q)
            StEmpty: begin
                if (acc) begin
                    head_d = sel_word;
                    occ_d  = StOne;
                end
            end
            StOne: begin
                if (acc && pop) begin
                    head_d = sel_word;
                end else if (acc) begin
                    skid_d = sel_word;
                    occ_d  = StTwo;
                end else if (pop) begin
                    occ_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    head_d = skid_q;
                    occ_d  = StOne;
                end
            end
            default: occ_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= StEmpty;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

`ifdef MUX_SEL_PIPE_CHECK_EN
    logic sel_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (acc && (32'(seletor) >= N_CH)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: a 4-channel instance checked against a queue model,
// plus a 3-channel instance for the out-of-range selector behaviour.
module tb_mux_sel_pipe;

`ifdef MUX_SEL_PIPE_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]   sel4;
    logic [127:0] din4;
    logic         iv4, ir4, ov4, or4, err4;
    logic [31:0]  mo4;

    logic [1:0]   sel3;
    logic [95:0]  din3;
    logic         iv3, ir3, ov3, or3, err3;
    logic [31:0]  mo3;

    mux_sel_pipe #(.WIDTH(32), .N_CH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .seletor   (sel4),
        .data_in   (din4),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .mux_out   (mo4),
        .out_valid (ov4),
        .out_ready (or4),
        .sel_err   (err4)
    );

    mux_sel_pipe #(.WIDTH(32), .N_CH(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .seletor   (sel3),
        .data_in   (din3),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .mux_out   (mo3),
        .out_valid (ov3),
        .out_ready (or3),
        .sel_err   (err3)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: words waiting for delivery, head first; capacity two.
    logic [31:0] mq[$];
    logic [31:0] fixed_ch[4];
    logic [127:0] fixed_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick4(input logic [127:0] d, input int s);
        logic [31:0] chans[4];
        for (int k = 0; k < 4; k++) chans[k] = d[k*32 +: 32];
        return chans[s];
    endfunction

    task automatic check4();
        chk("out_valid", 32'(ov4), 32'(mq.size() > 0));
        chk("in_ready", 32'(ir4), 32'(mq.size() < 2));
        if (mq.size() > 0) chk("mux_out", mo4, mq[0]);
    endtask

    task automatic step4(input logic v, input logic [1:0] s, input logic [127:0] d,
                         input logic r);
        bit acc, pop;
        iv4 = v;
        sel4 = s;
        din4 = d;
        or4 = r;
        acc = v && (mq.size() < 2);
        pop = r && (mq.size() > 0);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(pick4(d, int'(s)));
        #1;
        check4();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iv4 = 1'b1;
        or4 = 1'b0;
        iv3 = 1'b1;
        or3 = 1'b0;
        @(posedge clk);
        mq.delete();
        #1;
        chk("rst out_valid", 32'(ov4), 32'd0);
        chk("rst in_ready", 32'(ir4), 32'd1);
        chk("rst mux_out", mo4, 32'd0);
        chk("rst sel_err", 32'(err4), 32'd0);
        chk("rst3 out_valid", 32'(ov3), 32'd0);
        chk("rst3 in_ready", 32'(ir3), 32'd1);
        chk("rst3 mux_out", mo3, 32'd0);
        chk("rst3 sel_err", 32'(err3), 32'd0);
        reset = 1'b0;
        iv4 = 1'b0;
        iv3 = 1'b0;
    endtask

    initial begin
        fixed_ch[0] = 32'h11111111;
        fixed_ch[1] = 32'h22222222;
        fixed_ch[2] = 32'h33333333;
        fixed_ch[3] = 32'h44444444;
        fixed_din = {fixed_ch[3], fixed_ch[2], fixed_ch[1], fixed_ch[0]};
        reset = 1'b1;
        sel4 = '0;
        din4 = '0;
        iv4 = 1'b0;
        or4 = 1'b0;
        sel3 = '0;
        din3 = {32'hcccc0003, 32'hbbbb0002, 32'haaaa0001};
        iv3 = 1'b0;
        or3 = 1'b1;
        @(posedge clk);
        do_reset();

        // Streaming with sink always ready
        for (int i = 0; i < 4; i++) step4(1'b1, 2'(i), fixed_din, 1'b1);
        step4(1'b0, 2'd0, fixed_din, 1'b1);

        // Back-pressure fills both entries, third offer refused
        step4(1'b1, 2'd1, fixed_din, 1'b0);
        step4(1'b1, 2'd2, fixed_din, 1'b0);
        step4(1'b1, 2'd3, fixed_din, 1'b0);
        chk("bp mux_out held", mo4, 32'h22222222);
        step4(1'b1, 2'd3, fixed_din, 1'b1);
        chk("bp second word", mo4, 32'h33333333);
        step4(1'b1, 2'd3, fixed_din, 1'b1);
        chk("bp third word", mo4, 32'h44444444);
        step4(1'b0, 2'd0, fixed_din, 1'b1);

        // Random traffic
        repeat (300) begin
            step4(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        repeat (3) step4(1'b0, 2'd0, fixed_din, 1'b1);

        // Reset while full discards both held words
        step4(1'b1, 2'd0, fixed_din, 1'b0);
        step4(1'b1, 2'd1, fixed_din, 1'b0);
        do_reset();
        step4(1'b1, 2'd2, fixed_din, 1'b1);
        chk("post-reset first word", mo4, 32'h33333333);
        step4(1'b0, 2'd0, fixed_din, 1'b1);

        // Out-of-range selector on the 3-channel instance
        iv3 = 1'b1;
        sel3 = 2'd3;
        or3 = 1'b0;
        @(posedge clk);
        #1;
        chk("oor mux_out", mo3, 32'd0);
        chk("oor out_valid", 32'(ov3), 32'd1);
        chk("oor sel_err", 32'(err3), 32'(ERR_EXP));
        sel3 = 2'd1;
        or3 = 1'b1;
        @(posedge clk);
        #1;
        chk("oor next word", mo3, 32'hbbbb0002);
        chk("oor sel_err sticky", 32'(err3), 32'(ERR_EXP));
        iv3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("oor sel_err held", 32'(err3), 32'(ERR_EXP));
        chk("oor drained", 32'(ov3), 32'd0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
